garbage_attack_calc: RTL and testbench
======================================

GARBAGE_ATTACK_CALC -- requirements
Module: garbage_attack_calc

Interface
REQ-001 SHALL have parameter PLAYFIELD_ROWS, default 20: number of playfield rows in the lines_full mask.
REQ-002 SHALL have parameter MAX_APPLY, default 8: maximum garbage lines inserted per apply handshake.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 game_start  in  1  synchronous clear of all state.
REQ-006 lock_valid  in  1  one-cycle pulse: piece locked this cycle.
REQ-007 lines_full  in  [PLAYFIELD_ROWS] x 1  full-row mask, sampled with lock_valid.
REQ-008 tspin  in  1  locked piece was a T-spin, sampled with lock_valid.
REQ-009 garbage_recv_valid  in  1  opponent attack arriving this cycle.
REQ-010 garbage_recv_lines  in  4  lines in the arriving attack.
REQ-011 garbage_apply_ready  in  1  playfield accepts garbage insertion.
REQ-012 busy  out  1  high whenever state != IDLE.
REQ-013 attack_valid  out  1  one-cycle pulse: attack_lines sent to opponent.
REQ-014 attack_lines  out  4  lines sent after cancellation.
REQ-015 garbage_apply_valid  out  1  request to insert garbage_apply_lines rows.
REQ-016 garbage_apply_lines  out  4  rows to insert, 1..MAX_APPLY.
REQ-017 pending_garbage  out  5  queued incoming garbage, saturating at 31.
REQ-018 combo_cnt  out  5  consecutive clearing locks, saturating at 31.
REQ-019 b2b_active  out  1  last clearing lock was difficult.
REQ-020 lines_sent_total  out  8  cumulative attack_lines this game, saturating at 255.

Function
REQ-021 FSM states IDLE, CALC, SEND, APPLY; lock_valid accepted only in IDLE, ignored otherwise (no state change).
REQ-022 IDLE + lock_valid: latch n = popcount(lines_full) and tspin; -> CALC.
REQ-023 CALC, n>0: raw = base + b2b_bonus + combo_bonus; combo_cnt += 1; update b2b_active; -> SEND.
REQ-024 CALC, n=0: combo_cnt <= 0, b2b unchanged; -> APPLY if pending_garbage>0 and latch apply amount min(pending, MAX_APPLY), else -> IDLE.
REQ-025 base: non-tspin n=1/2/3/4 -> 0/1/2/4; tspin n=1/2/3 -> 2/4/6; n>4 treated as 4.
REQ-026 difficult = (n=4) or (tspin and n>0); b2b_bonus = 1 if difficult and b2b_active before update; b2b_active <= difficult.
REQ-027 combo_bonus by updated combo_cnt: 1 -> 0, 2-3 -> 1, 4-5 -> 2, 6-7 -> 3, >=8 -> 4.
REQ-028 SEND (one cycle): cancel = min(raw, pending_garbage); pending -= cancel; residual = raw - cancel; attack_valid=1 and attack_lines=residual only if residual>0; lines_sent_total += residual (saturate); -> IDLE.
REQ-029 Latency: lock_valid in cycle N -> attack_valid in cycle N+2.
REQ-030 APPLY: garbage_apply_valid held high with stable garbage_apply_lines until garbage_apply_ready; on valid&&ready pending -= garbage_apply_lines; -> IDLE.
REQ-031 garbage_recv_valid accepted in every state; pending = sat31(pending - decrement_this_cycle + garbage_recv_lines) when coincident with SEND cancel or APPLY handshake.
REQ-032 game_start: all outputs/counters to reset values, state -> IDLE; wins over lock_valid, garbage_recv_valid, handshake in the same cycle.
REQ-033 attack_valid, garbage_apply_valid, busy registered or decoded from state only; no combinational path from inputs.

Reset
REQ-034 rst asserted: state IDLE; all outputs 0; combo_cnt, b2b_active, pending_garbage, lines_sent_total 0; effective immediately regardless of clk.
REQ-035 rst or game_start during APPLY drops garbage_apply_valid without decrementing pending (pending cleared anyway).

Structure
REQ-036 Shared package holds AttackState_t enum, base-attack table, combo-bonus table, MAX_APPLY default and counter widths.
REQ-037 One sub-module attack_lut (combinational: n, tspin, b2b_prev, combo -> raw, difficult); everything else in garbage_attack_calc.

Verification
REQ-038 Tetris from reset, pending 0: n=4 -> attack_valid at N+2, attack_lines 4, b2b_active 1, combo_cnt 1; second Tetris next lock -> attack_lines 6 (4+1 b2b+1 combo).
REQ-039 Cancel: recv 5 lines, then T-spin double (raw 4) -> no attack_valid, pending 1; then single (raw 0, combo 2 -> 1) -> pending 0, no attack.
REQ-040 Apply: pending 11, non-clearing lock -> garbage_apply_lines 8, ready withheld 3 cycles, valid stable; after handshake pending 3, state IDLE.
REQ-041 Simultaneous: recv 4 in the same cycle as SEND cancelling 2 from pending 3 -> pending 5; recv to pending 30 plus 4 -> 31.
REQ-042 lock_valid while busy ignored; game_start with lock_valid same cycle -> all counters 0, no attack; rst mid-APPLY -> valid low asynchronously.

Source files
------------

// File: rtl/garbage_attack_calc_pkg.sv
// rtl/garbage_attack_calc_pkg.sv - shared types, widths and attack tables for garbage_attack_calc
package garbage_attack_calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_SEND  = 2'd2,
        ST_APPLY = 2'd3
    } AttackState_t;

    localparam int MAX_APPLY_DEFAULT = 8;
    localparam int CNT_W             = 5;
    localparam int TOTAL_W           = 8;
    localparam int LINES_W           = 4;
    localparam int NCLR_W            = 3;

    // n is already clamped to 0..4 by the caller
    function automatic logic [LINES_W-1:0] base_attack(input logic [NCLR_W-1:0] n,
                                                       input logic tspin);
        logic [LINES_W-1:0] b;
        b = '0;
        if (tspin) begin
            case (n)
                3'd1:    b = 4'd2;
                3'd2:    b = 4'd4;
                3'd3:    b = 4'd6;
                3'd4:    b = 4'd8;
                default: b = 4'd0;
            endcase
        end else begin
            case (n)
                3'd2:    b = 4'd1;
                3'd3:    b = 4'd2;
                3'd4:    b = 4'd4;
                default: b = 4'd0;
            endcase
        end
        return b;
    endfunction

    function automatic logic [2:0] combo_bonus(input logic [CNT_W-1:0] combo);
        logic [2:0] c;
        if (combo >= 5'd8)      c = 3'd4;
        else if (combo >= 5'd6) c = 3'd3;
        else if (combo >= 5'd4) c = 3'd2;
        else if (combo >= 5'd2) c = 3'd1;
        else                    c = 3'd0;
        return c;
    endfunction

endpackage

// File: rtl/garbage_attack_calc_lut.sv
// rtl/garbage_attack_calc_lut.sv - combinational raw-attack lookup (base + back-to-back + combo)
module attack_lut
    import garbage_attack_calc_pkg::*;
(
    input  logic [NCLR_W-1:0]  n,
    input  logic               tspin,
    input  logic               b2b_prev,
    input  logic [CNT_W-1:0]   combo,
    output logic [LINES_W-1:0] raw,
    output logic               difficult
);

    always_comb begin
        difficult = (n == 3'd4) || (tspin && (n != 3'd0));
        raw = base_attack(n, tspin)
            + {3'b000, difficult & b2b_prev}
            + {1'b0, combo_bonus(combo)};
    end

endmodule

// File: rtl/garbage_attack_calc.sv
// rtl/garbage_attack_calc.sv - line-clear attack, garbage cancellation and garbage insertion control
module garbage_attack_calc
    import garbage_attack_calc_pkg::*;
#(
    parameter int PLAYFIELD_ROWS = 20,
    parameter int MAX_APPLY      = MAX_APPLY_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      game_start,
    input  logic                      lock_valid,
    input  logic [PLAYFIELD_ROWS-1:0] lines_full,
    input  logic                      tspin,
    input  logic                      garbage_recv_valid,
    input  logic [LINES_W-1:0]        garbage_recv_lines,
    input  logic                      garbage_apply_ready,
    output logic                      busy,
    output logic                      attack_valid,
    output logic [LINES_W-1:0]        attack_lines,
    output logic                      garbage_apply_valid,
    output logic [LINES_W-1:0]        garbage_apply_lines,
    output logic [CNT_W-1:0]          pending_garbage,
    output logic [CNT_W-1:0]          combo_cnt,
    output logic                      b2b_active,
    output logic [TOTAL_W-1:0]        lines_sent_total
);

    AttackState_t        state;
    logic [NCLR_W-1:0]   n_q;
    logic                tspin_q;
    logic [LINES_W-1:0]  raw_q;
    logic [LINES_W-1:0]  apply_q;

    logic [NCLR_W-1:0]   n_in;
    logic [CNT_W-1:0]    combo_inc;
    logic [LINES_W-1:0]  raw;
    logic                difficult;
    logic [CNT_W-1:0]    cancel;
    logic [LINES_W-1:0]  residual;
    logic [CNT_W-1:0]    dec;
    logic [LINES_W-1:0]  recv_add;
    logic [CNT_W:0]      pending_sum;
    logic [CNT_W-1:0]    pending_next;
    logic [TOTAL_W:0]    total_sum;
    logic [LINES_W-1:0]  apply_amt;

    always_comb begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < PLAYFIELD_ROWS; i++) cnt += int'(lines_full[i]);
        n_in = (cnt > 4) ? 3'd4 : NCLR_W'(cnt);
    end

    assign combo_inc = (combo_cnt == '1) ? combo_cnt : combo_cnt + 5'd1;

    attack_lut u_lut (
        .n         (n_q),
        .tspin     (tspin_q),
        .b2b_prev  (b2b_active),
        .combo     (combo_inc),
        .raw       (raw),
        .difficult (difficult)
    );

    // Garbage already queued against us absorbs outgoing attack first
    assign cancel   = ({1'b0, raw_q} < pending_garbage) ? {1'b0, raw_q} : pending_garbage;
    assign residual = raw_q - cancel[LINES_W-1:0];

    always_comb begin
        dec = '0;
        if (state == ST_SEND)
            dec = cancel;
        else if (state == ST_APPLY && garbage_apply_ready)
            dec = {1'b0, apply_q};
        recv_add     = garbage_recv_valid ? garbage_recv_lines : '0;
        pending_sum  = {1'b0, pending_garbage} - {1'b0, dec} + {2'b00, recv_add};
        pending_next = (pending_sum > 6'd31) ? 5'd31 : pending_sum[CNT_W-1:0];
        total_sum    = {1'b0, lines_sent_total} + {5'b00000, residual};
        apply_amt    = (int'(pending_garbage) > MAX_APPLY) ? LINES_W'(MAX_APPLY)
                                                           : LINES_W'(pending_garbage);
    end

    assign busy                = (state != ST_IDLE);
    assign attack_valid        = (state == ST_SEND) && (residual != '0);
    assign attack_lines        = attack_valid ? residual : '0;
    assign garbage_apply_valid = (state == ST_APPLY);
    assign garbage_apply_lines = garbage_apply_valid ? apply_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            n_q              <= '0;
            tspin_q          <= 1'b0;
            raw_q            <= '0;
            apply_q          <= '0;
            pending_garbage  <= '0;
            combo_cnt        <= '0;
            b2b_active       <= 1'b0;
            lines_sent_total <= '0;
        end else if (game_start) begin
            state            <= ST_IDLE;
            n_q              <= '0;
            tspin_q          <= 1'b0;
            raw_q            <= '0;
            apply_q          <= '0;
            pending_garbage  <= '0;
            combo_cnt        <= '0;
            b2b_active       <= 1'b0;
            lines_sent_total <= '0;
        end else begin
            pending_garbage <= pending_next;
            case (state)
                ST_IDLE: begin
                    if (lock_valid) begin
                        n_q     <= n_in;
                        tspin_q <= tspin;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (n_q != '0) begin
                        combo_cnt  <= combo_inc;
                        b2b_active <= difficult;
                        raw_q      <= raw;
                        state      <= ST_SEND;
                    end else begin
                        combo_cnt <= '0;
                        if (pending_garbage != '0) begin
                            apply_q <= apply_amt;
                            state   <= ST_APPLY;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_SEND: begin
                    lines_sent_total <= total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
                    state            <= ST_IDLE;
                end
                ST_APPLY: begin
                    if (garbage_apply_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_garbage_attack_calc.sv
// tb/tb_garbage_attack_calc.sv - directed self-checking bench for garbage_attack_calc
module tb_garbage_attack_calc;

    logic        clk;
    logic        rst;
    logic        game_start;
    logic        lock_valid;
    logic [19:0] lines_full;
    logic        tspin;
    logic        garbage_recv_valid;
    logic [3:0]  garbage_recv_lines;
    logic        garbage_apply_ready;
    logic        busy;
    logic        attack_valid;
    logic [3:0]  attack_lines;
    logic        garbage_apply_valid;
    logic [3:0]  garbage_apply_lines;
    logic [4:0]  pending_garbage;
    logic [4:0]  combo_cnt;
    logic        b2b_active;
    logic [7:0]  lines_sent_total;

    int passed = 0;
    int total  = 0;

    garbage_attack_calc #(.PLAYFIELD_ROWS(20), .MAX_APPLY(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .game_start          (game_start),
        .lock_valid          (lock_valid),
        .lines_full          (lines_full),
        .tspin               (tspin),
        .garbage_recv_valid  (garbage_recv_valid),
        .garbage_recv_lines  (garbage_recv_lines),
        .garbage_apply_ready (garbage_apply_ready),
        .busy                (busy),
        .attack_valid        (attack_valid),
        .attack_lines        (attack_lines),
        .garbage_apply_valid (garbage_apply_valid),
        .garbage_apply_lines (garbage_apply_lines),
        .pending_garbage     (pending_garbage),
        .combo_cnt           (combo_cnt),
        .b2b_active          (b2b_active),
        .lines_sent_total    (lines_sent_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_lock(input logic [19:0] rows, input logic ts);
        lock_valid = 1'b1;
        lines_full = rows;
        tspin      = ts;
        step();
        lock_valid = 1'b0;
        lines_full = '0;
        tspin      = 1'b0;
    endtask

    task automatic do_recv(input logic [3:0] n);
        garbage_recv_valid = 1'b1;
        garbage_recv_lines = n;
        step();
        garbage_recv_valid = 1'b0;
        garbage_recv_lines = '0;
    endtask

    initial begin
        rst = 1'b1; game_start = 1'b0; lock_valid = 1'b0; lines_full = '0; tspin = 1'b0;
        garbage_recv_valid = 1'b0; garbage_recv_lines = '0; garbage_apply_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_attack_valid", attack_valid, 0);
        chk("rst_apply_valid", garbage_apply_valid, 0);
        chk("rst_pending", pending_garbage, 0);
        chk("rst_combo", combo_cnt, 0);
        chk("rst_b2b", b2b_active, 0);
        chk("rst_total", lines_sent_total, 0);

        // Tetris from reset, then a back-to-back Tetris
        do_lock(20'h0000F, 1'b0);
        chk("t1_calc_busy", busy, 1);
        chk("t1_calc_no_attack", attack_valid, 0);
        step();
        chk("t1_attack_valid", attack_valid, 1);
        chk("t1_attack_lines", attack_lines, 4);
        step();
        chk("t1_b2b", b2b_active, 1);
        chk("t1_combo", combo_cnt, 1);
        chk("t1_total", lines_sent_total, 4);
        chk("t1_idle", busy, 0);
        do_lock(20'hF0000, 1'b0);
        step();
        chk("t2_attack_valid", attack_valid, 1);
        chk("t2_attack_lines", attack_lines, 6);
        step();
        chk("t2_combo", combo_cnt, 2);
        chk("t2_total", lines_sent_total, 10);

        // Cancellation
        game_start = 1'b1; step(); game_start = 1'b0;
        chk("gs_total", lines_sent_total, 0);
        chk("gs_combo", combo_cnt, 0);
        chk("gs_b2b", b2b_active, 0);
        do_recv(4'd5);
        chk("c_pending5", pending_garbage, 5);
        do_lock(20'h00003, 1'b1);
        step();
        chk("c_tsd_no_attack", attack_valid, 0);
        step();
        chk("c_tsd_pending", pending_garbage, 1);
        chk("c_tsd_b2b", b2b_active, 1);
        do_lock(20'h00100, 1'b0);
        step();
        chk("c_single_no_attack", attack_valid, 0);
        step();
        chk("c_single_pending", pending_garbage, 0);
        chk("c_single_combo", combo_cnt, 2);
        chk("c_single_b2b", b2b_active, 0);
        chk("c_total", lines_sent_total, 0);

        // Garbage insertion with ready withheld
        do_recv(4'd11);
        do_lock(20'h00000, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("a_valid_held", garbage_apply_valid, 1);
            chk("a_lines_stable", garbage_apply_lines, 8);
            step();
        end
        chk("a_combo_cleared", combo_cnt, 0);
        garbage_apply_ready = 1'b1;
        step();
        garbage_apply_ready = 1'b0;
        chk("a_done_valid", garbage_apply_valid, 0);
        chk("a_done_pending", pending_garbage, 3);
        chk("a_done_idle", busy, 0);

        // Receive coincident with SEND cancel, then saturation
        do_lock(20'h00007, 1'b0);
        step();
        garbage_recv_valid = 1'b1; garbage_recv_lines = 4'd4;
        chk("s_no_attack", attack_valid, 0);
        step();
        garbage_recv_valid = 1'b0; garbage_recv_lines = '0;
        chk("s_pending5", pending_garbage, 5);
        do_recv(4'd15);
        do_recv(4'd10);
        chk("s_pending30", pending_garbage, 30);
        do_recv(4'd4);
        chk("s_pending_sat", pending_garbage, 31);

        // Lock while busy is ignored (Tetris raw 5 cancels 5 of 31)
        do_lock(20'h0F000, 1'b0);
        lock_valid = 1'b1; lines_full = 20'h0000F;
        step();
        lock_valid = 1'b0; lines_full = '0;
        chk("b_send_no_attack", attack_valid, 0);
        step();
        chk("b_ignored_idle", busy, 0);
        chk("b_pending26", pending_garbage, 26);
        chk("b_combo2", combo_cnt, 2);

        // game_start wins over lock and receive
        game_start = 1'b1; lock_valid = 1'b1; lines_full = 20'h0000F;
        garbage_recv_valid = 1'b1; garbage_recv_lines = 4'd3;
        step();
        game_start = 1'b0; lock_valid = 1'b0; lines_full = '0;
        garbage_recv_valid = 1'b0; garbage_recv_lines = '0;
        chk("g_busy", busy, 0);
        chk("g_pending", pending_garbage, 0);
        chk("g_combo", combo_cnt, 0);
        step();
        chk("g_no_attack", attack_valid, 0);

        // Asynchronous reset mid-APPLY
        do_recv(4'd9);
        do_lock(20'h00000, 1'b0);
        step();
        chk("r_apply_valid", garbage_apply_valid, 1);
        chk("r_apply_lines", garbage_apply_lines, 8);
        #2 rst = 1'b1;
        #1;
        chk("r_async_valid_low", garbage_apply_valid, 0);
        chk("r_async_pending", pending_garbage, 0);
        step();
        rst = 1'b0;
        step();
        chk("r_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
